// File: rtl/gpio_debounce_irq_pkg.sv
// Shared constants and types for the GPIO debounce/interrupt block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_debounce_irq_pkg;

   // Default pin count and debounce window used by the top level
   localparam int GPIO_WIDTH_DEFAULT      = 16;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // The edge counter is 8 bits wide and sticks at its maximum
   localparam logic [7:0] EDGE_CNT_MAX = 8'd255;

   // Pin vector at the default width
   typedef logic [GPIO_WIDTH_DEFAULT-1:0] gpio_vec_t;

   // Add an increment to the 8-bit edge counter, clamping at EDGE_CNT_MAX
   function automatic logic [7:0] edge_cnt_sat_add(input logic [7:0]  base,
                                                   input logic [15:0] inc);
      logic [16:0] sum;
      sum = {9'd0, base} + {1'b0, inc};
      if (sum > {9'd0, EDGE_CNT_MAX}) begin
         return EDGE_CNT_MAX;
      end
      return sum[7:0];
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO pin: two-flop synchronizer, stability counter, stable level and edge pulse.
// Latency: a held pin change reaches level 2+DEBOUNCE_CYCLES clocks after the first sampling edge.
// Backpressure: none; free-running. Falling edges pulse only with GPIO_DEBOUNCE_IRQ_FALL_EDGE_EN.
module gpio_debounce_bit
   import gpio_debounce_irq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic edge_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The new level is taken on the cycle the disagreement has lasted the full window
   assign accept = (s2 != stable) && (cnt == CNT_LAST);

   // Two-flop synchronizer: nothing downstream looks at the raw pin
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   // Count consecutive cycles where the synchronized pin disagrees with the stable level
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (s2 == stable) begin
         cnt <= '0;
      end else if (accept) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign level = stable;

`ifdef GPIO_DEBOUNCE_IRQ_FALL_EDGE_EN
   // Any accepted level change is an event
   assign edge_pulse = accept;
`else
   // Only accepted 0->1 changes are events; falls just move the level
   assign edge_pulse = accept & s2;
`endif

endmodule

// File: rtl/gpio_debounce_irq.sv
// Debounced GPIO bank with latched per-pin edge flags, masked interrupt and saturating edge counter.
// Latency: level/pending 2+DEBOUNCE_CYCLES clocks after a held pin change; irq one clock after pending.
// Backpressure: none; clears are single-cycle strobes, a same-cycle set beats a clear.
// Falling-edge events are enabled by defining GPIO_DEBOUNCE_IRQ_FALL_EDGE_EN.
module gpio_debounce_irq
   import gpio_debounce_irq_pkg::*;
#(
   parameter int GPIO_WIDTH      = GPIO_WIDTH_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   input  logic [GPIO_WIDTH-1:0] irq_mask,
   input  logic                  clr_valid,
   input  logic [GPIO_WIDTH-1:0] clr_mask,
   input  logic                  cnt_clr,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic [GPIO_WIDTH-1:0] pending,
   output logic                  irq,
   output logic [7:0]            edge_count
);

   logic [GPIO_WIDTH-1:0] edge_vec;
   logic [GPIO_WIDTH-1:0] clr_vec;
   logic [15:0]           edge_pop;
   logic [7:0]            cnt_base;

   // One debounce slice per pin
   for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_bit
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk        (clk),
         .rst        (rst),
         .pin        (gpio_in[g]),
         .level      (gpio_out[g]),
         .edge_pulse (edge_vec[g])
      );
   end

   assign clr_vec  = clr_valid ? clr_mask : '0;
   assign cnt_base = (clr_valid && cnt_clr) ? 8'd0 : edge_count;

   // Number of pins reporting an event this cycle
   always_comb begin
      edge_pop = '0;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
         edge_pop = edge_pop + 16'(edge_vec[i]);
      end
   end

   // Sticky event flags: clear first, then OR in new events so a set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_vec) | edge_vec;
      end
   end

   // Interrupt reflects the registered flags and mask of the previous cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else begin
         irq <= |(pending & irq_mask);
      end
   end

   // Event counter, masked pins included; a counter clear still keeps this cycle's events
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_count <= 8'd0;
      end else begin
         edge_count <= edge_cnt_sat_add(cnt_base, edge_pop);
      end
   end

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Directed bench for gpio_debounce_irq at 16 pins, 4-cycle debounce.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_debounce_irq;
   import gpio_debounce_irq_pkg::*;

`ifdef GPIO_DEBOUNCE_IRQ_FALL_EDGE_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   gpio_vec_t   gpio_in;
   gpio_vec_t   irq_mask;
   logic        clr_valid;
   gpio_vec_t   clr_mask;
   logic        cnt_clr;
   gpio_vec_t   gpio_out;
   gpio_vec_t   pending;
   logic        irq;
   logic [7:0]  edge_count;

   int          checks;
   int          failures;
   gpio_vec_t   cur_in;
   gpio_vec_t   exp_pend;
   int          exp_cnt;

   gpio_debounce_irq #(
      .GPIO_WIDTH      (16),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gpio_in    (gpio_in),
      .irq_mask   (irq_mask),
      .clr_valid  (clr_valid),
      .clr_mask   (clr_mask),
      .cnt_clr    (cnt_clr),
      .gpio_out   (gpio_out),
      .pending    (pending),
      .irq        (irq),
      .edge_count (edge_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pop16(input logic [15:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) n += int'(v[i]);
      return n;
   endfunction

   // Drive a new pin pattern, hold it long enough to settle, and update the expected state
   task automatic settle(input logic [15:0] v);
      logic [15:0] rises;
      logic [15:0] falls;
      logic [15:0] evs;
      rises   = v & ~cur_in;
      falls   = ~v & cur_in;
      evs     = FALL_EN ? (rises | falls) : rises;
      gpio_in = v;
      repeat (8) tick();
      exp_cnt  = exp_cnt + pop16(evs);
      if (exp_cnt > 255) exp_cnt = 255;
      exp_pend = exp_pend | evs;
      cur_in   = v;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      cur_in    = '0;
      exp_pend  = '0;
      exp_cnt   = 0;
      rst       = 1'b1;
      gpio_in   = '0;
      irq_mask  = 16'hFFFF;
      clr_valid = 1'b0;
      clr_mask  = '0;
      cnt_clr   = 1'b0;
      tick();
      tick();
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_edge_count", 32'(edge_count), 32'h0);
      rst = 1'b0;
      tick();
      chk("first_cycle_no_event", 32'(pending), 32'h0);

      // Single rising edge on bit 0: six edges to the output
      gpio_in = 16'h0001;
      repeat (5) tick();
      chk("rise_not_yet", 32'(gpio_out), 32'h0);
      tick();
      chk("rise_gpio_out", 32'(gpio_out), 32'h0001);
      chk("rise_pending", 32'(pending), 32'h0001);
      chk("rise_irq_not_yet", 32'(irq), 32'h0);
      chk("rise_edge_count", 32'(edge_count), 32'd1);
      tick();
      chk("rise_irq", 32'(irq), 32'h1);
      cur_in   = 16'h0001;
      exp_pend = 16'h0001;
      exp_cnt  = 1;

      // Three-cycle glitch on bit 3 is rejected
      gpio_in = 16'h0009;
      repeat (3) tick();
      gpio_in = 16'h0001;
      repeat (8) tick();
      chk("glitch_gpio_out", 32'(gpio_out), 32'h0001);
      chk("glitch_pending", 32'(pending), 32'h0001);
      chk("glitch_edge_count", 32'(edge_count), 32'd1);

      // Clear colliding with a new bit 0 edge: the set wins
      settle(16'h0000);
      chk("fall0_pending", 32'(pending), 32'(exp_pend));
      gpio_in = 16'h0001;
      repeat (5) tick();
      clr_valid = 1'b1;
      clr_mask  = 16'h0001;
      tick();
      clr_valid = 1'b0;
      clr_mask  = '0;
      exp_cnt   = exp_cnt + 1;
      cur_in    = 16'h0001;
      chk("set_wins_pending", 32'(pending), 32'h0001);
      chk("set_wins_edge_count", 32'(edge_count), 32'(exp_cnt));
      tick();
      clr_valid = 1'b1;
      clr_mask  = 16'h0001;
      tick();
      clr_valid = 1'b0;
      clr_mask  = '0;
      exp_pend  = '0;
      chk("clear_pending", 32'(pending), 32'h0);
      chk("clear_irq_lags", 32'(irq), 32'h1);
      tick();
      chk("clear_irq_falls", 32'(irq), 32'h0);

      // Falling transition of bit 0
      gpio_in = 16'h0000;
      repeat (5) tick();
      chk("fall_not_yet", 32'(gpio_out), 32'h0001);
      tick();
      cur_in   = 16'h0000;
      exp_cnt  = exp_cnt + (FALL_EN ? 1 : 0);
      exp_pend = FALL_EN ? 16'h0001 : 16'h0000;
      chk("fall_gpio_out", 32'(gpio_out), 32'h0);
      chk("fall_pending", 32'(pending), 32'(exp_pend));
      chk("fall_edge_count", 32'(edge_count), 32'(exp_cnt));

      // Wipe flags and counter, then drive the counter toward saturation
      clr_valid = 1'b1;
      cnt_clr   = 1'b1;
      clr_mask  = 16'hFFFF;
      tick();
      clr_valid = 1'b0;
      cnt_clr   = 1'b0;
      clr_mask  = '0;
      exp_cnt   = 0;
      exp_pend  = '0;
      chk("cnt_clr_count", 32'(edge_count), 32'h0);
      chk("cnt_clr_pending", 32'(pending), 32'h0);
      for (int k = 0; k < 15; k++) begin
         settle(16'hFFFF);
         settle(16'h0000);
      end
      settle(16'h03FF);
      chk("count_pre_sat", 32'(edge_count), 32'(exp_cnt));

      // Masked interrupts: flags and counting continue, irq stays low
      irq_mask  = '0;
      clr_valid = 1'b1;
      clr_mask  = 16'hFFFF;
      tick();
      clr_valid = 1'b0;
      clr_mask  = '0;
      exp_pend  = '0;
      settle(16'hFFFF);
      chk("masked_pending", 32'(pending), 32'(exp_pend));
      chk("masked_irq", 32'(irq), 32'h0);
      chk("sat_edge_count", 32'(edge_count), 32'd255);
      settle(16'h0000);
      settle(16'hFFFF);
      chk("sat_hold", 32'(edge_count), 32'd255);
      irq_mask = 16'hFFFF;
      tick();
      tick();
      chk("unmasked_irq", 32'(irq), 32'h1);
      clr_valid = 1'b1;
      cnt_clr   = 1'b1;
      tick();
      clr_valid = 1'b0;
      cnt_clr   = 1'b0;
      exp_cnt   = 0;
      chk("sat_clear", 32'(edge_count), 32'h0);

      // Counter clear on the same cycle as four new edges
      settle(16'h0000);
      gpio_in = 16'h000F;
      repeat (5) tick();
      clr_valid = 1'b1;
      cnt_clr   = 1'b1;
      tick();
      clr_valid = 1'b0;
      cnt_clr   = 1'b0;
      cur_in    = 16'h000F;
      chk("clr_with_edges", 32'(edge_count), 32'd4);

      // Reset in the middle of a bit 5 debounce, input kept high
      gpio_in = 16'h002F;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_gpio_out", 32'(gpio_out), 32'h0);
      chk("midrst_pending", 32'(pending), 32'h0);
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_edge_count", 32'(edge_count), 32'h0);
      repeat (5) tick();
      chk("postrst_not_yet", 32'(gpio_out), 32'h0);
      tick();
      chk("postrst_gpio_out", 32'(gpio_out), 32'h002F);
      chk("postrst_pending", 32'(pending), 32'h002F);
      chk("postrst_edge_count", 32'(edge_count), 32'd5);
      tick();
      chk("postrst_irq", 32'(irq), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
